// File: rtl/vga_tile_ctrl.sv
// rtl/vga_tile_ctrl.sv - tiled-framebuffer VGA scan-out with direct RGB222 or 16-entry palette colour
module vga_tile_ctrl #(
   parameter int          VGA_BITS  = 8,
   parameter int          H_ACTIVE  = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter int          SYNC_NEG  = 1,
   parameter int          TILE_LOG2 = 4,
   parameter logic [31:0] FB_BASE   = 32'h0,
   parameter int          RD_LAT    = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         vdata,
   output logic [31:0]         vaddr,
   input  logic                mode,
   input  logic                pal_we,
   input  logic [3:0]          pal_addr,
   input  logic [11:0]         pal_wdata,
   output logic [VGA_BITS-1:0] VGA_R,
   output logic [VGA_BITS-1:0] VGA_G,
   output logic [VGA_BITS-1:0] VGA_B,
   output logic                VGA_HS_O,
   output logic                VGA_VS_O,
   output logic                de,
   output logic                vblank_irq,
   output logic [15:0]         frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int TILE    = 1 << TILE_LOG2;
   localparam int COLS    = (H_ACTIVE + TILE - 1) >> TILE_LOG2;
   localparam int SW      = 6;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic          SYNC_INV = (SYNC_NEG != 0);

   logic [HW-1:0]  hcount;
   logic [VW-1:0]  vcount;
   logic           mode_lat;
   logic           at_origin;
   logic           active;
   logic           hs_act;
   logic           vs_act;
   logic           mode_eff;
   logic [HW-1:0]  col;
   logic [VW-1:0]  row;
   logic [31:0]    tile_off;
   logic [SW-1:0]  stage_in;
   logic [SW-1:0]  stage_tap;
   logic           tap_mode;
   logic           tap_de;
   logic           tap_hs;
   logic           tap_vs;
   logic [1:0]     tap_sel;
   logic [11:0]    pal [16];
   logic [7:0]     pix_byte;
   logic [11:0]    pal_entry;
   logic [VGA_BITS-1:0] r_nx;
   logic [VGA_BITS-1:0] g_nx;
   logic [VGA_BITS-1:0] b_nx;
   logic           pix_unused;

   always_ff @(posedge clk) begin
      if (reset) begin
         hcount      <= '0;
         vcount      <= '0;
         frame_count <= '0;
         mode_lat    <= 1'b0;
      end else begin
         if (hcount == H_LAST) begin
            hcount <= '0;
            if (vcount == V_LAST) begin
               vcount      <= '0;
               frame_count <= frame_count + 16'd1;
            end else begin
               vcount <= vcount + VW'(1);
            end
         end else begin
            hcount <= hcount + HW'(1);
         end
         if (at_origin) mode_lat <= mode;
      end
   end

   assign at_origin = (hcount == '0) && (vcount == '0);
   assign active    = (hcount < H_ACT) && (vcount < V_ACT);
   assign hs_act    = (hcount >= HS_BEG) && (hcount <= HS_END);
   assign vs_act    = (vcount >= VS_BEG) && (vcount <= VS_END);

   // The origin pixel must already use the freshly sampled mode.
   assign mode_eff  = at_origin ? mode : mode_lat;

   assign col      = hcount >> TILE_LOG2;
   assign row      = vcount >> TILE_LOG2;
   assign tile_off = 32'(row) * 32'(COLS) + 32'(col);
   assign vaddr    = active ? (FB_BASE + tile_off) : FB_BASE;

   assign stage_in = {mode_eff, active, hs_act, vs_act, (active ? tile_off[1:0] : 2'b00)};

   // Control bits ride alongside the memory read so they meet the returning byte.
   generate
      if (RD_LAT == 0) begin : g_nolat
         assign stage_tap = stage_in;
      end else begin : g_lat
         logic [SW-1:0] dly [RD_LAT];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < RD_LAT; i++) dly[i] <= '0;
            end else begin
               dly[0] <= stage_in;
               for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
            end
         end
         assign stage_tap = dly[RD_LAT-1];
      end
   endgenerate

   assign {tap_mode, tap_de, tap_hs, tap_vs, tap_sel} = stage_tap;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) pal[i] <= '0;
      end else if (pal_we) begin
         pal[pal_addr] <= pal_wdata;
      end
   end

   always_comb begin
      pix_byte = 8'h00;
      case (tap_sel)
         2'd0:    pix_byte = vdata[31:24];
         2'd1:    pix_byte = vdata[23:16];
         2'd2:    pix_byte = vdata[15:8];
         default: pix_byte = vdata[7:0];
      endcase
      pal_entry = pal[pix_byte[3:0]];
      r_nx = '0;
      g_nx = '0;
      b_nx = '0;
      if (tap_de) begin
         if (tap_mode) begin
            r_nx = VGA_BITS'(pal_entry[11:8]) << (VGA_BITS - 4);
            g_nx = VGA_BITS'(pal_entry[7:4])  << (VGA_BITS - 4);
            b_nx = VGA_BITS'(pal_entry[3:0])  << (VGA_BITS - 4);
         end else begin
            r_nx = VGA_BITS'(pix_byte[5:4]) << (VGA_BITS - 2);
            g_nx = VGA_BITS'(pix_byte[3:2]) << (VGA_BITS - 2);
            b_nx = VGA_BITS'(pix_byte[1:0]) << (VGA_BITS - 2);
         end
      end
   end

   assign pix_unused = ^pix_byte[7:6];

   always_ff @(posedge clk) begin
      if (reset) begin
         VGA_R      <= '0;
         VGA_G      <= '0;
         VGA_B      <= '0;
         de         <= 1'b0;
         VGA_HS_O   <= SYNC_INV;
         VGA_VS_O   <= SYNC_INV;
         vblank_irq <= 1'b0;
      end else begin
         VGA_R      <= r_nx;
         VGA_G      <= g_nx;
         VGA_B      <= b_nx;
         de         <= tap_de;
         VGA_HS_O   <= tap_hs ^ SYNC_INV;
         VGA_VS_O   <= tap_vs ^ SYNC_INV;
         // Frame interrupt is taken straight from the counters, not the pixel pipe.
         vblank_irq <= (hcount == '0) && (vcount == V_ACT);
      end
   end

endmodule

// File: tb/tb_vga_tile_ctrl.sv
// tb/tb_vga_tile_ctrl.sv - scoreboard bench for vga_tile_ctrl on a reduced raster
module tb_vga_tile_ctrl;

   localparam int VB   = 8;
   localparam int HA   = 64;
   localparam int HFP  = 4;
   localparam int HSW  = 8;
   localparam int HBP  = 4;
   localparam int VA   = 32;
   localparam int VFP  = 2;
   localparam int VSW  = 2;
   localparam int VBP  = 4;
   localparam int TL   = 4;
   localparam int LAT  = 2;
   localparam logic [31:0] BASE = 32'h100;
   localparam int HT   = HA + HFP + HSW + HBP;
   localparam int VT   = VA + VFP + VSW + VBP;
   localparam int COLS = (HA + (1 << TL) - 1) >> TL;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic       md;
      logic [7:0] b;
   } pix_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   vdata;
   logic [31:0]   vaddr;
   logic          mode;
   logic          pal_we;
   logic [3:0]    pal_addr;
   logic [11:0]   pal_wdata;
   logic [VB-1:0] vga_r, vga_g, vga_b;
   logic          vga_hs, vga_vs, de, vblank_irq;
   logic [15:0]   frame_count;

   vga_tile_ctrl #(
      .VGA_BITS(VB), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_NEG(1),
      .TILE_LOG2(TL), .FB_BASE(BASE), .RD_LAT(LAT)
   ) dut (
      .clk(clk), .reset(reset), .vdata(vdata), .vaddr(vaddr), .mode(mode),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
      .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
      .VGA_HS_O(vga_hs), .VGA_VS_O(vga_vs), .de(de),
      .vblank_irq(vblank_irq), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [2];
   logic [31:0] adly1, adly2, aoff;

   always @(posedge clk) begin
      adly1 <= vaddr;
      adly2 <= adly1;
   end

   always_comb begin
      aoff  = adly2 - BASE;
      vdata = (aoff < 32'd8) ? mem[aoff[2]] : 32'h0;
   end

   int n_vec = 0;
   int n_err = 0;
   int hc, vc, fc, frame;
   logic mlat, irq_exp, we_prev, rst_pending;
   logic [3:0]  wa_prev;
   logic [11:0] wd_prev;
   logic [15:0][11:0] mp, pal_lag;
   pix_t q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s (h=%0d v=%0d frame=%0d): got %h expected %h", tag, hc, vc, frame, obs, expv);
      end
   endtask

   function automatic pix_t make_rec(input int h, input int v, input logic m);
      pix_t p;
      int idx;
      logic [31:0] w;
      p    = '0;
      p.de = (h < HA) && (v < VA);
      p.hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
      p.vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
      p.md = m;
      if (p.de) begin
         idx = (v >> TL) * COLS + (h >> TL);
         w   = mem[idx >> 2];
         p.b = w[31 - 8 * (idx % 4) -: 8];
      end
      return p;
   endfunction

   function automatic logic [31:0] exp_pix(input pix_t p);
      logic [11:0] e;
      logic [7:0]  r, g, b;
      r = 8'h0; g = 8'h0; b = 8'h0;
      if (p.de) begin
         if (p.md) begin
            e = pal_lag[p.b[3:0]];
            r = {e[11:8], 4'h0};
            g = {e[7:4], 4'h0};
            b = {e[3:0], 4'h0};
         end else begin
            r = {p.b[5:4], 6'h0};
            g = {p.b[3:2], 6'h0};
            b = {p.b[1:0], 6'h0};
         end
      end
      return {5'b0, p.de, p.hs, p.vs, r, g, b};
   endfunction

   function automatic logic [31:0] exp_vaddr(input int h, input int v);
      if ((h < HA) && (v < VA)) return BASE + 32'((v >> TL) * COLS + (h >> TL));
      return BASE;
   endfunction

   task automatic model_reset();
      pix_t rr;
      hc = 0; vc = 0; fc = 0;
      mp = '0; mlat = 1'b0; irq_exp = 1'b0; we_prev = 1'b0;
      rr = '0; rr.hs = 1'b1; rr.vs = 1'b1;
      q.delete();
      repeat (LAT + 1) q.push_back(rr);
   endtask

   task automatic pal_write(input logic [3:0] a, input logic [11:0] d);
      pal_we = 1'b1; pal_addr = a; pal_wdata = d;
   endtask

   initial begin
      pix_t p;
      mem[0] = 32'h3F300C03;
      mem[1] = 32'h052AF53C;
      reset = 1'b1; mode = 1'b0; pal_we = 1'b0; pal_addr = 4'h0; pal_wdata = 12'h0;
      frame = 0; rst_pending = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (rst_pending) begin
            reset = 1'b0;
            rst_pending = 1'b0;
            model_reset();
            frame = 4;
         end
         pal_lag = mp;
         if (we_prev) mp[wa_prev] = wd_prev;

         p = q.pop_front();
         check("pixel", {5'b0, de, vga_hs, vga_vs, vga_r, vga_g, vga_b}, exp_pix(p));
         check("vaddr", vaddr, exp_vaddr(hc, vc));
         check("vblank_irq", 32'(vblank_irq), 32'(irq_exp));
         check("frame_count", 32'(frame_count), 32'(fc));
         if (frame == 3 && hc == 0 && vc == 0) check("frame_count_3", 32'(frame_count), 32'd3);
         if (frame == 5) break;

         pal_we = 1'b0;
         if (frame == 0 && hc == 10 && vc == 5)  pal_write(4'd5, 12'hA5F);
         if (frame == 0 && hc == 20 && vc == 5)  pal_write(4'd10, 12'h123);
         if (frame == 0 && hc == 20 && vc == 6)  pal_write(4'd12, 12'h9C6);
         if (frame == 0 && hc == 30 && vc == 10) mode = 1'b1;
         if (frame == 1 && hc == 2 + LAT && vc == 16) pal_write(4'd5, 12'h0F0);
         if (frame == 1 && hc == 40 && vc == 20) mode = 1'b0;
         if (frame == 3 && hc == 50 && vc == 20) begin
            reset = 1'b1;
            rst_pending = 1'b1;
         end
         we_prev = pal_we; wa_prev = pal_addr; wd_prev = pal_wdata;

         if (hc == 0 && vc == 0) mlat = mode;
         q.push_back(make_rec(hc, vc, mlat));
         irq_exp = (hc == 0) && (vc == VA);

         if (!rst_pending) begin
            if (hc == HT - 1) begin
               hc = 0;
               if (vc == VT - 1) begin
                  vc = 0;
                  fc = (fc + 1) % 65536;
                  frame++;
               end else begin
                  vc++;
               end
            end else begin
               hc++;
            end
         end
      end
      check("run_complete", 32'(frame), 32'd5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
